// File: rtl/turn_sequencer.sv
// Player-side win-check sequencer: pick edge -> one-cycle B issue -> W sample -> continue/pass/done.
// Latency: B one cycle after the pick edge, W sampled one cycle later; optional idle timeout via `TURN_TIMEOUT_EN.
module turn_sequencer #(
    parameter int NUM_TILES = 24,
    parameter int GOAL_POS  = 23,
    parameter int TIMEOUT   = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pick,
    input  logic [4:0] sel,
    input  logic       W,
    input  logic [4:0] afterposition_data,
    output logic [1:0] T,
    output logic [4:0] N,
    output logic       B,
    output logic       busy,
    output logic       reject,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {IDLE, ISSUE, RESULT, PASS, DONE} state_t;

    localparam logic [5:0] TILE_LIM = 6'(NUM_TILES);
    localparam logic [4:0] GOAL     = 5'(GOAL_POS);

    state_t      state;
    logic        pick_q;
    logic        pick_edge;
    logic        sel_ok;
    logic        to_hit;
    // Bits at and above NUM_TILES are never set, so indexing by any 5-bit value is safe.
    logic [31:0] mask;

    assign pick_edge = pick & ~pick_q;
    assign sel_ok    = ({1'b0, sel} < TILE_LIM) && !mask[sel];

`ifdef TURN_TIMEOUT_EN
    logic [31:0] to_cnt;

    assign to_hit = (state == IDLE) && (to_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state != IDLE || pick_edge || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 32'd1;
        end
    end
`else
    // TIMEOUT is only meaningful with the timeout build; IDLE waits forever here.
    assign to_hit = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pick_q    <= 1'b0;
            mask      <= '0;
            T         <= '0;
            N         <= '0;
            B         <= 1'b0;
            busy      <= 1'b0;
            reject    <= 1'b0;
            game_over <= 1'b0;
            winner    <= '0;
        end else begin
            pick_q <= pick;
            B      <= 1'b0;
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    // A pick edge takes precedence over a coincident timeout.
                    if (pick_edge) begin
                        if (sel_ok) begin
                            N     <= sel;
                            B     <= 1'b1;
                            busy  <= 1'b1;
                            state <= ISSUE;
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (to_hit) begin
                        state <= PASS;
                    end
                end
                ISSUE: begin
                    mask[N] <= 1'b1;
                    state   <= RESULT;
                end
                RESULT: begin
                    busy <= 1'b0;
                    if (W) begin
                        if (afterposition_data >= GOAL) begin
                            winner    <= T;
                            game_over <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state <= PASS;
                    end
                end
                PASS: begin
                    T     <= T + 2'd1;
                    mask  <= '0;
                    state <= IDLE;
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
